// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes and control width shared by the ALU and its arbiter
package alu_pkg;
    localparam int ALU_CTRL_WIDTH = 3;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ID  = 3'd0;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = 3'd1;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = 3'd2;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_EQ  = 3'd3;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_LE  = 3'd4;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_GE  = 3'd5;
endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter searching upward from rr_ptr with wrap
//   clk, reset (async, active-high) | req[N] in | grant[N] one-hot out | grant_idx out
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);
    logic [W-1:0] rr_ptr;
    logic [N-1:0] hi;
    logic [N-1:0] sel;
    // Requests at or above the pointer win; otherwise wrap to the lowest request overall.
    always_comb begin
        hi = '0;
        for (int i = 0; i < N; i++) hi[i] = req[i] && (i >= int'(rr_ptr));
        sel = (|hi) ? hi : req;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) if (sel[i]) grant_idx = W'(i);
        grant = (|req) ? (N'(1) << grant_idx) : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_ptr <= '0;
        else if (|req) rr_ptr <= (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered-operand ALU among N_REQ requesters, result two cycles after grant
//   clk, reset (async, active-high)
//   req_valid/req_ready[N_REQ] handshake, req_ctrl/req_in0/req_in1 packed per requester
//   resp_valid[N_REQ] one-hot strobe, resp_data shared result bus
//   alu_ctrl/alu_in0/alu_in1 to the ALU, alu_out from the ALU
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int ID_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [ALU_CTRL_WIDTH*N_REQ-1:0] req_ctrl,
    input  logic [DATA_WIDTH*N_REQ-1:0]   req_in0,
    input  logic [DATA_WIDTH*N_REQ-1:0]   req_in1,
    output logic [N_REQ-1:0]              resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ALU_CTRL_WIDTH-1:0]     alu_ctrl,
    output logic [DATA_WIDTH-1:0]         alu_in0,
    output logic [DATA_WIDTH-1:0]         alu_in1,
    input  logic [DATA_WIDTH-1:0]         alu_out
);
    logic [N_REQ-1:0]          req;
    logic [N_REQ-1:0]          grant;
    logic [ID_WIDTH-1:0]       g;
    logic                      any;
    logic                      s1_valid;
    logic [ALU_CTRL_WIDTH-1:0] s1_ctrl;
    logic [ID_WIDTH-1:0]       s1_id;
    // Masking requests during reset keeps req_ready low while reset is held.
    assign req = reset ? '0 : req_valid;
    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_idx(g)
    );
    assign any       = |grant;
    assign req_ready = grant;
    assign alu_in0   = any ? req_in0[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign alu_in1   = any ? req_in1[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    // ctrl lags operands by one cycle to meet the ALU's operand registers.
    assign alu_ctrl  = s1_ctrl;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_ctrl    <= '0;
            s1_id      <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            s1_valid   <= any;
            s1_ctrl    <= any ? req_ctrl[g*ALU_CTRL_WIDTH +: ALU_CTRL_WIDTH] : '0;
            s1_id      <= g;
            resp_valid <= s1_valid ? (N_REQ'(1) << s1_id) : '0;
            if (s1_valid) resp_data <= alu_out;
        end
    end
endmodule
